// File: rtl/dlsc_stereobm_rowwindow.sv
// dlsc_stereobm_rowwindow
//
// Vertical window generator for the stereo block-matching frontend. Accepts a
// raster stream of pixel columns for CHANNELS image planes and, for every
// accepted column, produces the WIN most recent rows of that column. The rows
// are read from a per-channel row buffer and then written back shifted by one
// row.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cfg_width       columns per row (2..MAX_WIDTH), taken at frame start
//   cfg_height      rows per frame (>=1), taken at frame start
//   cfg_pad         1: zero-pad rows above the image, 0: crop first WIN-1 rows
//   in_ready/valid  input handshake; in_data holds one pixel per channel
//   out_ready/valid output handshake; out_data holds the WIN x CHANNELS window
//                   (row w, channel c at [((w*CHANNELS)+c)*DATA +: DATA],
//                   w=WIN-1 is the current row)
//   out_row_first   window belongs to column 0
//   out_row_last    window belongs to column cfg_width-1
//   out_frame_last  window belongs to the last column of the last row

// Simulation checker: flags an illegal frame width when a frame starts.
module dlsc_stereobm_rowwindow_chk #(
    parameter int MAX_WIDTH = 384,
    parameter int XB        = $clog2(MAX_WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          check_en,
    input  logic [XB-1:0] cfg_width
);
    localparam logic [XB:0] MIN_W = (XB+1)'(2);
    localparam logic [XB:0] MAX_W = (XB+1)'(MAX_WIDTH);

    // Check the width sampled for each new frame.
    always_ff @(posedge clk) begin
        if (!rst && check_en) begin
            assert (({1'b0, cfg_width} >= MIN_W) && ({1'b0, cfg_width} <= MAX_W))
                else $error("illegal cfg_width %0d", cfg_width);
        end
    end
endmodule

module dlsc_stereobm_rowwindow #(
    parameter int DATA      = 8,
    parameter int CHANNELS  = 2,
    parameter int WIN       = 17,
    parameter int MAX_WIDTH = 384,
    parameter int XB        = $clog2(MAX_WIDTH),
    parameter int YB        = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [XB-1:0]                cfg_width,
    input  logic [YB-1:0]                cfg_height,
    input  logic                         cfg_pad,
    output logic                         in_ready,
    input  logic                         in_valid,
    input  logic [CHANNELS*DATA-1:0]     in_data,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [WIN*CHANNELS*DATA-1:0] out_data,
    output logic                         out_row_first,
    output logic                         out_row_last,
    output logic                         out_frame_last
);
    // Stored rows per channel (all but the current one).
    localparam int SW = (WIN-1)*DATA;
    localparam int OW = WIN*CHANNELS*DATA;
    localparam logic [YB-1:0] CROP_ROWS = YB'(WIN-1);

    logic advance_s;
    logic accept_s;

    // Frame configuration and position
    logic            fresh_r;
    logic [XB-1:0]   width_r;
    logic [YB-1:0]   height_r;
    logic            pad_r;
    logic [XB-1:0]   eff_width_s;
    logic [YB-1:0]   eff_height_s;
    logic            eff_pad_s;
    logic [XB-1:0]   col_r;
    logic [YB-1:0]   row_r;
    logic            last_col_s;
    logic            last_row_s;
    logic            emit_s;

    // S1 stage
    logic                     s1_valid_r;
    logic [XB-1:0]            s1_col_r;
    logic                     s1_row0_r;
    logic                     s1_emit_r;
    logic [CHANNELS*DATA-1:0] s1_pix_r;
    logic                     s1_row_first_r;
    logic                     s1_row_last_r;
    logic                     s1_frame_last_r;

    logic                     wr_en_s;
    logic [CHANNELS*SW-1:0]   stored_s;
    logic [OW-1:0]            win_s;

    // The whole pipeline moves together whenever the output register is free.
    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;
    assign accept_s  = in_valid && advance_s;
    assign wr_en_s   = s1_valid_r && advance_s;

    // Configuration is taken straight from the inputs on the first beat of a
    // frame, and from the latched copy for the rest of it.
    always_comb begin
        eff_width_s  = width_r;
        eff_height_s = height_r;
        eff_pad_s    = pad_r;
        if (fresh_r) begin
            eff_width_s  = cfg_width;
            eff_height_s = cfg_height;
            eff_pad_s    = cfg_pad;
        end else begin
            eff_width_s  = width_r;
            eff_height_s = height_r;
            eff_pad_s    = pad_r;
        end
    end

    assign last_col_s = (col_r == (eff_width_s - XB'(1)));
    assign last_row_s = (row_r == (eff_height_s - YB'(1)));
    assign emit_s     = eff_pad_s || (row_r >= CROP_ROWS);

    // Column/row counters and per-frame configuration latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            fresh_r  <= 1'b1;
            col_r    <= {XB{1'b0}};
            row_r    <= {YB{1'b0}};
            width_r  <= {XB{1'b0}};
            height_r <= {YB{1'b0}};
            pad_r    <= 1'b0;
        end else if (accept_s) begin
            if (fresh_r) begin
                width_r  <= cfg_width;
                height_r <= cfg_height;
                pad_r    <= cfg_pad;
            end
            if (last_col_s) begin
                col_r <= {XB{1'b0}};
                if (last_row_s) begin
                    row_r   <= {YB{1'b0}};
                    fresh_r <= 1'b1;
                end else begin
                    row_r   <= row_r + YB'(1);
                    fresh_r <= 1'b0;
                end
            end else begin
                col_r   <= col_r + XB'(1);
                fresh_r <= 1'b0;
            end
        end
    end

    // S1 register: beat data and position travel alongside the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r      <= 1'b0;
            s1_col_r        <= {XB{1'b0}};
            s1_row0_r       <= 1'b0;
            s1_emit_r       <= 1'b0;
            s1_pix_r        <= {(CHANNELS*DATA){1'b0}};
            s1_row_first_r  <= 1'b0;
            s1_row_last_r   <= 1'b0;
            s1_frame_last_r <= 1'b0;
        end else if (advance_s) begin
            s1_valid_r      <= accept_s;
            s1_col_r        <= col_r;
            s1_row0_r       <= (row_r == {YB{1'b0}});
            s1_emit_r       <= emit_s;
            s1_pix_r        <= in_data;
            s1_row_first_r  <= (col_r == {XB{1'b0}});
            s1_row_last_r   <= last_col_s;
            s1_frame_last_r <= last_col_s && last_row_s;
        end
    end

    // Per-channel row buffer: one word per column holding the WIN-1 older rows.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SW-1:0] mem [MAX_WIDTH];
        logic [SW-1:0] rd_q;
        logic [SW-1:0] stored_g;
        logic [SW-1:0] wr_data_g;

        // Row 0 masking hides whatever an earlier frame left in the buffer.
        assign stored_g = s1_row0_r ? {SW{1'b0}} : rd_q;

        // Drop the oldest row and append the new pixel as the newest stored row.
        if (WIN == 2) begin : g_w2
            assign wr_data_g = s1_pix_r[g*DATA +: DATA];
        end else begin : g_wn
            assign wr_data_g = {s1_pix_r[g*DATA +: DATA], stored_g[SW-1:DATA]};
        end

        assign stored_s[g*SW +: SW] = stored_g;

        // Simple dual-port RAM: write-back from S1, read for the incoming beat.
        // Addresses always differ because consecutive beats hit different columns.
        always_ff @(posedge clk) begin
            if (wr_en_s) begin
                mem[s1_col_r] <= wr_data_g;
            end
            if (advance_s) begin
                rd_q <= mem[col_r];
            end
        end
    end

    // Assemble the window: stored rows below, the current pixel on top.
    always_comb begin
        win_s = {OW{1'b0}};
        for (int w = 0; w < WIN-1; w++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                win_s[((w*CHANNELS)+c)*DATA +: DATA] = stored_s[c*SW + w*DATA +: DATA];
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            win_s[(((WIN-1)*CHANNELS)+c)*DATA +: DATA] = s1_pix_r[c*DATA +: DATA];
        end
    end

    // S2 control: valid and position flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_row_first  <= 1'b0;
            out_row_last   <= 1'b0;
            out_frame_last <= 1'b0;
        end else if (advance_s) begin
            out_valid      <= s1_valid_r && s1_emit_r;
            out_row_first  <= s1_row_first_r;
            out_row_last   <= s1_row_last_r;
            out_frame_last <= s1_frame_last_r;
        end
    end

    // S2 data: window register (no reset needed, qualified by out_valid).
    always_ff @(posedge clk) begin
        if (advance_s) begin
            out_data <= win_s;
        end
    end

    dlsc_stereobm_rowwindow_chk #(
        .MAX_WIDTH (MAX_WIDTH),
        .XB        (XB)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .check_en  (accept_s && fresh_r),
        .cfg_width (cfg_width)
    );
endmodule

// File: tb/tb_dlsc_stereobm_rowwindow.sv
// Self-checking bench for dlsc_stereobm_rowwindow (WIN=3, 2 channels).
module tb_dlsc_stereobm_rowwindow;
    localparam int DATA = 8;
    localparam int CH   = 2;
    localparam int WIN  = 3;
    localparam int MAXW = 384;
    localparam int XB   = $clog2(MAXW);
    localparam int YB   = 12;
    localparam int OW   = WIN*CH*DATA;

    logic            clk;
    logic            rst;
    logic [XB-1:0]   cfg_width;
    logic [YB-1:0]   cfg_height;
    logic            cfg_pad;
    logic            in_ready;
    logic            in_valid;
    logic [CH*DATA-1:0] in_data;
    logic            out_ready;
    logic            out_valid;
    logic [OW-1:0]   out_data;
    logic            out_row_first;
    logic            out_row_last;
    logic            out_frame_last;

    dlsc_stereobm_rowwindow #(
        .DATA(DATA), .CHANNELS(CH), .WIN(WIN), .MAX_WIDTH(MAXW), .XB(XB), .YB(YB)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_pad(cfg_pad),
        .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_row_first(out_row_first), .out_row_last(out_row_last),
        .out_frame_last(out_frame_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          rf;
        logic          rl;
        logic          fl;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks    = 0;
    int   errors    = 0;
    int   n_out     = 0;
    int   cyc       = 0;
    int   first_acc = -1;
    int   first_out = -1;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pix(int base, int r, int c, int ch);
        return 8'(base + r*16 + c + (c/256)*7 + ch*128);
    endfunction

    // Reference window: rows above the image are zero.
    function automatic exp_t model(int base, int r, int c, int width, int height);
        exp_t m;
        int   src;
        m = '0;
        for (int w = 0; w < WIN; w++) begin
            src = r - (WIN-1) + w;
            for (int ch = 0; ch < CH; ch++) begin
                m.data[((w*CH)+ch)*DATA +: DATA] = (src < 0) ? 8'h00 : pix(base, src, c, ch);
            end
        end
        m.rf = (c == 0);
        m.rl = (c == width-1);
        m.fl = (c == width-1) && (r == height-1);
        return m;
    endfunction

    // Output monitor / scoreboard pop, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (in_ready === (!out_valid || out_ready)) else begin
                errors++;
                $error("FAIL in_ready obs=%b exp=%b", in_ready, (!out_valid || out_ready));
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (first_out < 0) first_out = cyc;
                n_out++;
                checks++;
                assert (q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_output obs=%0d exp=%0d", 1, 0);
                end
                if (q.size() != 0) begin
                    e = q.pop_front();
                    checks++;
                    assert (out_data === e.data) else begin
                        errors++;
                        $error("FAIL window obs=%h exp=%h", out_data, e.data);
                    end
                    checks++;
                    assert ({out_row_first, out_row_last, out_frame_last} === {e.rf, e.rl, e.fl}) else begin
                        errors++;
                        $error("FAIL flags obs=%b exp=%b",
                               {out_row_first, out_row_last, out_frame_last}, {e.rf, e.rl, e.fl});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic check_int(string tag, int obs, int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, expv);
        end
    endtask

    // Stream a frame (or its first max_beats beats), pushing expected windows.
    task automatic send_frame(int width, int height, bit pad, int base, int max_beats);
        int beats = 0;
        bit done;
        for (int r = 0; r < height; r++) begin
            for (int c = 0; c < width; c++) begin
                if (beats >= max_beats) begin
                    in_valid = 1'b0;
                    return;
                end
                cfg_width  = XB'(width);
                cfg_height = YB'(height);
                cfg_pad    = pad;
                in_valid   = 1'b1;
                for (int ch = 0; ch < CH; ch++) in_data[ch*DATA +: DATA] = pix(base, r, c, ch);
                done = 1'b0;
                for (int k = 0; k < 64 && !done; k++) begin
                    @(negedge clk);
                    if (in_ready === 1'b1) begin
                        done = 1'b1;
                        if (first_acc < 0) first_acc = cyc;
                        if (pad || r >= WIN-1) q.push_back(model(base, r, c, width, height));
                    end
                    tick();
                end
                checks++;
                assert (done) else begin
                    errors++;
                    $error("FAIL accept_timeout obs=%0d exp=%0d", 0, 1);
                end
                beats++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        in_valid = 1'b0;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (q.size() == 0 && out_valid !== 1'b1) break;
            tick();
        end
        tick();
        check_int("drain_timeout", (k < 400) ? 1 : 0, 1);
    endtask

    int n0;

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        cfg_width  = XB'(4);
        cfg_height = YB'(3);
        cfg_pad    = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_int("reset_out_valid", int'(out_valid), 0);
        check_int("reset_flags", int'({out_row_first, out_row_last, out_frame_last}), 0);
        tick();

        // Padded frame, full throughput, plus first-output latency.
        n0 = n_out;
        send_frame(4, 3, 1'b1, 0, 1000);
        drain();
        check_int("pad_count", n_out - n0, 12);
        check_int("latency", first_out - first_acc, 2);

        // Cropped frame: only row 2 comes out.
        n0 = n_out;
        send_frame(4, 3, 1'b0, 0, 1000);
        drain();
        check_int("crop_count", n_out - n0, 4);

        // Random backpressure.
        rand_ready = 1'b1;
        n0 = n_out;
        send_frame(4, 3, 1'b1, 0, 1000);
        send_frame(4, 3, 1'b0, 0, 1000);
        drain();
        check_int("bp_count", n_out - n0, 16);
        rand_ready = 1'b0;
        tick();

        // Back-to-back frames, second one narrower with distinct data.
        n0 = n_out;
        send_frame(4, 3, 1'b1, 0, 1000);
        send_frame(2, 3, 1'b1, 8'h40, 1000);
        drain();
        check_int("b2b_count", n_out - n0, 18);

        // Reset in the middle of row 1 (at column 2).
        send_frame(4, 3, 1'b1, 0, 6);
        rst        = 1'b1;
        in_valid   = 1'b1;
        for (int ch = 0; ch < CH; ch++) in_data[ch*DATA +: DATA] = pix(0, 1, 2, ch);
        q.delete();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_int("midreset_out_valid", int'(out_valid), 0);
        tick();
        n0 = n_out;
        send_frame(4, 3, 1'b1, 8'h30, 1000);
        drain();
        check_int("after_reset_count", n_out - n0, 12);

        // Maximum width, cropped, WIN+1 rows.
        n0 = n_out;
        send_frame(MAXW, WIN+1, 1'b0, 5, 100000);
        drain();
        check_int("maxw_count", n_out - n0, 2*MAXW);
        check_int("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dlsc_stereobm_rowwindow.md
Name: dlsc_stereobm_rowwindow

Overview:
- Parametrised successor to the stereo frontend row buffer.
- Accepts a raster stream of pixel columns for CHANNELS independent image planes (e.g. left/right/aux) and emits a WIN-row vertical window per column.
- Adds runtime-programmable frame size, output backpressure (ready/valid on both sides) and a selectable top-border mode (crop or zero-pad).
- Sits between the input DMA/converter and the SAD/texture pipelines.

Parameters:
- DATA, 8, bits per pixel per channel.
- CHANNELS, 2, independent image planes carried in parallel.
- WIN, 17, window height in rows (>=2).
- MAX_WIDTH, 384, row buffer depth in columns.
- XB, clog2(MAX_WIDTH), column counter/address width (derived).
- YB, 12, row counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_width  in  XB  columns per row, 2..MAX_WIDTH; sampled at frame start.
- cfg_height  in  YB  rows per frame, >=1; sampled at frame start.
- cfg_pad  in  1  0 = crop (suppress first WIN-1 rows); 1 = zero-pad rows above the image. Sampled at frame start.
- in_ready  out  1  block can accept a column.
- in_valid  in  1  column valid.
- in_data  in  CHANNELS*DATA  one pixel per channel; channel c at [c*DATA +: DATA].
- out_ready  in  1  consumer accepts the output.
- out_valid  out  1  out_* valid.
- out_data  out  WIN*CHANNELS*DATA  window column; row w, channel c at [((w*CHANNELS)+c)*DATA +: DATA]; w=WIN-1 is the current input row, w=0 the oldest.
- out_row_first  out  1  column 0 of a row.
- out_row_last  out  1  column cfg_width-1.
- out_frame_last  out  1  last column of the last row.

Behaviour:
- Reset: out_valid=0; out_row_first, out_row_last and out_frame_last = 0; col=0, row=0; cfg re-sampled on the next accepted beat. RAM contents are not reset. Reset mid-frame abandons the frame; the next accepted beat is treated as row 0, column 0.
- Pipeline:
  - S1 = RAM read issued with the beat.
  - S2 = output register.
  - advance = !out_valid | out_ready.
  - in_ready = advance (registered-equivalent; no combinational path from in_valid).
  - Beat accepted at cycle t with out_ready held 1: out_valid at t+2.
  - Full throughput: 1 column/cycle.
  - While stalled, S1/S2 data, RAM read data and flags hold unchanged.
- Row buffer:
  - Per channel, one MAX_WIDTH x ((WIN-1)*DATA) simple dual-port RAM, 1-cycle read latency, read enable gated by advance.
  - In S1, read addr = col. In S2, stored = read data (masked to 0 when row==0), window = {new pixel, stored}.
  - Write-back to addr col = {new pixel, stored rows 1..WIN-2}: the oldest row is dropped and the new row is appended.
  - Write and read addresses differ on every cycle because cfg_width>=2, so there is no read/write collision.
- Counters:
  - col increments on accept; at cfg_width-1 it wraps to 0 and row increments.
  - At the last column of row cfg_height-1, row wraps to 0 and the next frame's cfg is sampled.
- Output gating:
  - cfg_pad=1: every accepted beat produces an output. Rows above the image read as 0 (row r exposes zeros in w < WIN-1-r).
  - cfg_pad=0: beats with row < WIN-1 are written to RAM but produce no output; frames with cfg_height < WIN produce no output at all.
  - The window never contains data from a previous frame: row==0 masking makes stale RAM content invisible.
- Flags: out_row_first / out_row_last / out_frame_last are computed from the S1 counters and travel with the data. They are meaningful only while out_valid is high.
- Width rules: all counters are unsigned; cfg_width > MAX_WIDTH or cfg_width < 2 is illegal (no checking required; a simulation assertion fires).

Test Plan:
- Reset then cfg_width=4, cfg_height=3, WIN=3, cfg_pad=1, out_ready=1, pixel = row*16+col, CHANNELS=2 with ch1 = ch0+128 -> 12 outputs. Row 2 col 1 window (w0..w2) = 0x01, 0x11, 0x21; ch1 = 0x81, 0x91, 0xA1. Row 0 windows have w0=w1=0. First output 2 cycles after the first accept.
- Same frame with cfg_pad=0 -> exactly 4 outputs (row 2 only). out_row_first on col0, out_row_last and out_frame_last on col3.
- Random out_ready (50%) with continuous in_valid -> output sequence identical to the out_ready=1 run. No drop or duplicate. in_ready low only while out_valid && !out_ready.
- Back-to-back frames with a second frame of cfg_width=2 and distinct data under cfg_pad=1 -> second frame's row 0 windows contain zeros, not first-frame pixels. New width honoured from the first beat.
- rst asserted mid-row (row 1, col 2) for 1 cycle, then restart -> out_valid=0 the cycle after reset. The next beat is treated as row 0 col 0 with a zero-masked window.
- cfg_width=MAX_WIDTH, cfg_height=WIN+1, cfg_pad=0 -> 2*MAX_WIDTH outputs. Column wrap at MAX_WIDTH-1 is correct and there are no address-collision errors.
